// File: rtl/alu_op_decoder_pkg.sv
// Shared types for the ALU opcode decoder: opcodes, selector encoding,
// decoded bundle layout and skid-buffer states.
package alu_op_decoder_pkg;

  typedef enum logic [3:0] {
    OP_ADD  = 4'h0,
    OP_SUB  = 4'h1,
    OP_AND  = 4'h2,
    OP_OR   = 4'h3,
    OP_NOR  = 4'h4,
    OP_XOR  = 4'h5,
    OP_SLL  = 4'h6,
    OP_SRL  = 4'h7,
    OP_SRA  = 4'h8,
    OP_ADDI = 4'h9,
    OP_SUBI = 4'hA
  } op_e;

  localparam logic [3:0] SEL_ADD = 4'd0;
  localparam logic [3:0] SEL_SUB = 4'd1;
  localparam logic [3:0] SEL_AND = 4'd2;
  localparam logic [3:0] SEL_OR  = 4'd3;
  localparam logic [3:0] SEL_NOR = 4'd4;
  localparam logic [3:0] SEL_XOR = 4'd5;
  localparam logic [3:0] SEL_SLL = 4'd6;
  localparam logic [3:0] SEL_SRL = 4'd7;
  localparam logic [3:0] SEL_SRA = 4'd8;
  localparam logic [3:0] SEL_INV = 4'hF;

  typedef struct packed {
    logic [3:0] alu_sel;
    logic       use_imm;
    logic [3:0] rd;
    logic [3:0] rs;
    logic [3:0] rt;
    logic       reg_we;
    logic       illegal;
  } bundle_t;

  localparam bundle_t BUNDLE_RST = bundle_t'{SEL_INV, 1'b0, 4'h0, 4'h0, 4'h0, 1'b0, 1'b0};

  typedef enum logic [1:0] {
    S_EMPTY = 2'd0,
    S_ONE   = 2'd1,
    S_TWO   = 2'd2
  } skid_e;

  // Result mux of the downstream ALU, keyed by the same selector constants.
  function automatic logic [15:0] alu_result(input logic [3:0] sel,
                                             input logic [15:0] a,
                                             input logic [15:0] b);
    logic [15:0] r;
    r = 16'h0000;
    case (sel)
      SEL_ADD: r = a + b;
      SEL_SUB: r = a - b;
      SEL_AND: r = a & b;
      SEL_OR:  r = a | b;
      SEL_NOR: r = ~(a | b);
      SEL_XOR: r = a ^ b;
      SEL_SLL: r = a << b[3:0];
      SEL_SRL: r = a >> b[3:0];
      SEL_SRA: r = $unsigned($signed(a) >>> b[3:0]);
      default: r = 16'h0000;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/alu_op_decoder_if.sv
// Handshake and decoded-bundle signals between the instruction source,
// the decoder and the consumer of decoded bundles.
interface alu_op_decoder_if #(parameter int CNT_W = 16);
  logic             in_valid;
  logic [15:0]      instr;
  logic             in_ready;
  logic             out_valid;
  logic             out_ready;
  logic [3:0]       alu_sel;
  logic             use_imm;
  logic [3:0]       rd;
  logic [3:0]       rs;
  logic [3:0]       rt;
  logic             reg_we;
  logic             illegal;
  logic [CNT_W-1:0] err_count;

  modport master (
    output in_valid, instr, out_ready,
    input  in_ready, out_valid, alu_sel, use_imm, rd, rs, rt, reg_we, illegal, err_count
  );

  modport slave (
    input  in_valid, instr, out_ready,
    output in_ready, out_valid, alu_sel, use_imm, rd, rs, rt, reg_we, illegal, err_count
  );
endinterface

// File: rtl/alu_op_table.sv
// Pure combinational opcode-to-bundle table; register fields pass straight
// through, undefined opcodes map to the invalid selector with illegal set.
module alu_op_table
  import alu_op_decoder_pkg::*;
(
  input  logic [15:0] instr,
  output bundle_t     bundle
);

  op_e op;
  assign op = op_e'(instr[15:12]);

  always_comb begin
    bundle         = BUNDLE_RST;
    bundle.rd      = instr[11:8];
    bundle.rs      = instr[7:4];
    bundle.rt      = instr[3:0];
    bundle.reg_we  = 1'b1;
    bundle.illegal = 1'b0;
    case (op)
      OP_ADD:  bundle.alu_sel = SEL_ADD;
      OP_SUB:  bundle.alu_sel = SEL_SUB;
      OP_AND:  bundle.alu_sel = SEL_AND;
      OP_OR:   bundle.alu_sel = SEL_OR;
      OP_NOR:  bundle.alu_sel = SEL_NOR;
      OP_XOR:  bundle.alu_sel = SEL_XOR;
      OP_SLL:  bundle.alu_sel = SEL_SLL;
      OP_SRL:  bundle.alu_sel = SEL_SRL;
      OP_SRA:  bundle.alu_sel = SEL_SRA;
      OP_ADDI: begin
        bundle.alu_sel = SEL_ADD;
        bundle.use_imm = 1'b1;
      end
      OP_SUBI: begin
        bundle.alu_sel = SEL_SUB;
        bundle.use_imm = 1'b1;
      end
      default: begin
        bundle.alu_sel = SEL_INV;
        bundle.reg_we  = 1'b0;
        bundle.illegal = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/alu_op_decoder.sv
// Registered opcode decoder with a 2-entry skid buffer and a saturating
// illegal-opcode counter.
//
//   state   | meaning
//   S_EMPTY | no bundle held, out_valid low
//   S_ONE   | head register holds the presented bundle
//   S_TWO   | head presented, skid holds the next bundle, in_ready low
module alu_op_decoder
  import alu_op_decoder_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic           clk,
  input  logic           reset,
  alu_op_decoder_if.slave bus
);

  skid_e            state_q, state_d;
  logic             in_ready_q;
  bundle_t          head_q, skid_q, dec_b;
  logic [CNT_W-1:0] err_q;
  logic             in_fire, out_fire;
  logic             load_head_new, load_head_skid, load_skid;

  alu_op_table u_table (
    .instr  (bus.instr),
    .bundle (dec_b)
  );

  assign in_fire  = bus.in_valid & in_ready_q;
  assign out_fire = (state_q != S_EMPTY) & bus.out_ready;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= S_EMPTY;
      in_ready_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      in_ready_q <= (state_d != S_TWO);
    end
  end

  always_comb begin
    state_d        = state_q;
    load_head_new  = 1'b0;
    load_head_skid = 1'b0;
    load_skid      = 1'b0;
    case (state_q)
      S_EMPTY: begin
        if (in_fire) begin
          state_d       = S_ONE;
          load_head_new = 1'b1;
        end
      end
      S_ONE: begin
        if (in_fire && out_fire) begin
          load_head_new = 1'b1;
        end else if (in_fire) begin
          state_d   = S_TWO;
          load_skid = 1'b1;
        end else if (out_fire) begin
          state_d = S_EMPTY;
        end
      end
      S_TWO: begin
        if (out_fire) begin
          state_d        = S_ONE;
          load_head_skid = 1'b1;
        end
      end
      default: state_d = S_EMPTY;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      head_q <= BUNDLE_RST;
      skid_q <= BUNDLE_RST;
    end else begin
      if (load_head_new)       head_q <= dec_b;
      else if (load_head_skid) head_q <= skid_q;
      if (load_skid)           skid_q <= dec_b;
    end
  end

  // Counter holds at all-ones instead of wrapping.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      err_q <= '0;
    end else if (in_fire && dec_b.illegal && (err_q != {CNT_W{1'b1}})) begin
      err_q <= err_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = (state_q != S_EMPTY);
  assign bus.alu_sel   = head_q.alu_sel;
  assign bus.use_imm   = head_q.use_imm;
  assign bus.rd        = head_q.rd;
  assign bus.rs        = head_q.rs;
  assign bus.rt        = head_q.rt;
  assign bus.reg_we    = head_q.reg_we;
  assign bus.illegal   = head_q.illegal;
  assign bus.err_count = err_q;

endmodule

// File: tb/tb_alu_op_decoder.sv
// Directed self-checking bench for alu_op_decoder: a default-width instance
// plus a CNT_W=2 instance for counter saturation.
module tb_alu_op_decoder;

  logic clk = 1'b0;
  logic reset;
  int   n_checks = 0;
  int   n_fail   = 0;

  alu_op_decoder_if #(.CNT_W(16)) bus1 ();
  alu_op_decoder_if #(.CNT_W(2))  bus2 ();

  alu_op_decoder #(.CNT_W(16)) u_dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus1.slave)
  );

  alu_op_decoder #(.CNT_W(2)) u_dut2 (
    .clk   (clk),
    .reset (reset),
    .bus   (bus2.slave)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // {out_valid, alu_sel, use_imm, rd, rs, rt, reg_we, illegal}
  function automatic logic [19:0] obs1();
    return {bus1.out_valid, bus1.alu_sel, bus1.use_imm, bus1.rd, bus1.rs, bus1.rt,
            bus1.reg_we, bus1.illegal};
  endfunction

  task automatic test_reset();
    logic [19:0] exp_rst;
    exp_rst = {1'b0, 4'hF, 1'b0, 4'h0, 4'h0, 4'h0, 1'b0, 1'b0};
    reset = 1'b1;
    bus1.in_valid = 1'b0; bus1.instr = 16'h0000; bus1.out_ready = 1'b0;
    bus2.in_valid = 1'b0; bus2.instr = 16'h0000; bus2.out_ready = 1'b1;
    repeat (2) step();
    n_checks++;
    if (obs1() !== exp_rst) begin
      n_fail++; $display("FAIL reset_bundle: got %h expected %h", obs1(), exp_rst);
    end
    n_checks++;
    if (bus1.in_ready !== 1'b0) begin
      n_fail++; $display("FAIL reset_in_ready: got %b expected 0", bus1.in_ready);
    end
    n_checks++;
    if (bus1.err_count !== 16'd0) begin
      n_fail++; $display("FAIL reset_err_count: got %0d expected 0", bus1.err_count);
    end
    reset = 1'b0;
    #1;
    n_checks++;
    if (bus1.in_ready !== 1'b0) begin
      n_fail++; $display("FAIL ready_before_edge: got %b expected 0", bus1.in_ready);
    end
    step();
    n_checks++;
    if (bus1.in_ready !== 1'b1) begin
      n_fail++; $display("FAIL ready_after_edge: got %b expected 1", bus1.in_ready);
    end
  endtask

  task automatic test_basic();
    logic [19:0] exp_b;
    exp_b = {1'b1, 4'h0, 1'b0, 4'h1, 4'h2, 4'h3, 1'b1, 1'b0};
    bus1.out_ready = 1'b1;
    bus1.in_valid  = 1'b1;
    bus1.instr     = 16'h0123;
    step();
    bus1.in_valid = 1'b0;
    bus1.instr    = 16'hFFFF;
    n_checks++;
    if (obs1() !== exp_b) begin
      n_fail++; $display("FAIL basic_add: got %h expected %h", obs1(), exp_b);
    end
    step();
    n_checks++;
    if (bus1.out_valid !== 1'b0) begin
      n_fail++; $display("FAIL basic_drain: out_valid got %b expected 0", bus1.out_valid);
    end
  endtask

  task automatic test_decode();
    logic [15:0] vin [4];
    logic [19:0] vexp [4];
    vin[0] = 16'h9A57; vexp[0] = {1'b1, 4'h0, 1'b1, 4'hA, 4'h5, 4'h7, 1'b1, 1'b0};
    vin[1] = 16'h8334; vexp[1] = {1'b1, 4'h8, 1'b0, 4'h3, 4'h3, 4'h4, 1'b1, 1'b0};
    vin[2] = 16'h6C2D; vexp[2] = {1'b1, 4'h6, 1'b0, 4'hC, 4'h2, 4'hD, 1'b1, 1'b0};
    vin[3] = 16'hA0F1; vexp[3] = {1'b1, 4'h1, 1'b1, 4'h0, 4'hF, 4'h1, 1'b1, 1'b0};
    bus1.out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      bus1.in_valid = 1'b1;
      bus1.instr    = vin[i];
      step();
      bus1.in_valid = 1'b0;
      n_checks++;
      if (obs1() !== vexp[i]) begin
        n_fail++; $display("FAIL decode_%h: got %h expected %h", vin[i], obs1(), vexp[i]);
      end
      step();
    end
  endtask

  task automatic test_illegal();
    logic [19:0] e1, e2;
    e1 = {1'b1, 4'hF, 1'b0, 4'h0, 4'h0, 4'h0, 1'b0, 1'b1};
    e2 = {1'b1, 4'hF, 1'b0, 4'h1, 4'h2, 4'h3, 1'b0, 1'b1};
    bus1.out_ready = 1'b1;
    bus1.in_valid  = 1'b1;
    bus1.instr     = 16'hF000;
    step();
    bus1.in_valid = 1'b0;
    n_checks++;
    if (obs1() !== e1) begin
      n_fail++; $display("FAIL illegal_f000: got %h expected %h", obs1(), e1);
    end
    n_checks++;
    if (bus1.err_count !== 16'd1) begin
      n_fail++; $display("FAIL illegal_count1: got %0d expected 1", bus1.err_count);
    end
    step();
    bus1.in_valid = 1'b1;
    bus1.instr    = 16'hB123;
    step();
    bus1.in_valid = 1'b0;
    n_checks++;
    if (obs1() !== e2) begin
      n_fail++; $display("FAIL illegal_b123: got %h expected %h", obs1(), e2);
    end
    n_checks++;
    if (bus1.err_count !== 16'd2) begin
      n_fail++; $display("FAIL illegal_count2: got %0d expected 2", bus1.err_count);
    end
    // illegal opcode on instr without in_valid must be ignored
    bus1.instr = 16'hC000;
    repeat (2) step();
    n_checks++;
    if (bus1.err_count !== 16'd2 || bus1.out_valid !== 1'b0) begin
      n_fail++; $display("FAIL illegal_ignored: err_count %0d out_valid %b expected 2 and 0",
                         bus1.err_count, bus1.out_valid);
    end
  endtask

  task automatic test_saturate();
    logic [1:0] exp_cnt [4];
    exp_cnt[0] = 2'd1; exp_cnt[1] = 2'd2; exp_cnt[2] = 2'd3; exp_cnt[3] = 2'd3;
    bus2.out_ready = 1'b1;
    bus2.in_valid  = 1'b1;
    for (int i = 0; i < 4; i++) begin
      bus2.instr = 16'hE000 | 16'(i);
      step();
      n_checks++;
      if (bus2.err_count !== exp_cnt[i]) begin
        n_fail++; $display("FAIL saturate_%0d: got %0d expected %0d", i, bus2.err_count, exp_cnt[i]);
      end
    end
    bus2.in_valid = 1'b0;
    step();
  endtask

  task automatic test_backpressure();
    logic [19:0] b1, b2, b3;
    b1 = {1'b1, 4'h1, 1'b0, 4'h1, 4'h1, 4'h1, 1'b1, 1'b0};
    b2 = {1'b1, 4'h2, 1'b0, 4'h2, 4'h2, 4'h2, 1'b1, 1'b0};
    b3 = {1'b1, 4'h3, 1'b0, 4'h3, 4'h3, 4'h3, 1'b1, 1'b0};
    bus1.out_ready = 1'b0;
    bus1.in_valid  = 1'b1;
    bus1.instr     = 16'h1111;
    step();
    n_checks++;
    if (bus1.in_ready !== 1'b1 || obs1() !== b1) begin
      n_fail++; $display("FAIL bp_first: in_ready %b bundle %h expected 1 and %h", bus1.in_ready, obs1(), b1);
    end
    bus1.instr = 16'h2222;
    step();
    n_checks++;
    if (bus1.in_ready !== 1'b0 || obs1() !== b1) begin
      n_fail++; $display("FAIL bp_full: in_ready %b bundle %h expected 0 and %h", bus1.in_ready, obs1(), b1);
    end
    bus1.instr = 16'h3333;
    step();
    n_checks++;
    if (bus1.in_ready !== 1'b0 || obs1() !== b1) begin
      n_fail++; $display("FAIL bp_hold: in_ready %b bundle %h expected 0 and %h", bus1.in_ready, obs1(), b1);
    end
    bus1.out_ready = 1'b1;
    step();
    n_checks++;
    if (bus1.in_ready !== 1'b1 || obs1() !== b2) begin
      n_fail++; $display("FAIL bp_second: in_ready %b bundle %h expected 1 and %h", bus1.in_ready, obs1(), b2);
    end
    step();
    bus1.in_valid = 1'b0;
    n_checks++;
    if (obs1() !== b3) begin
      n_fail++; $display("FAIL bp_third: got %h expected %h", obs1(), b3);
    end
    step();
    n_checks++;
    if (bus1.out_valid !== 1'b0) begin
      n_fail++; $display("FAIL bp_drain: out_valid got %b expected 0", bus1.out_valid);
    end
  endtask

  task automatic test_back_to_back();
    logic [3:0]  exp_sel [11];
    logic        exp_imm [11];
    logic [19:0] e;
    for (int i = 0; i < 11; i++) begin
      exp_sel[i] = (i <= 8) ? 4'(i) : 4'(i - 9);
      exp_imm[i] = (i >= 9);
    end
    bus1.out_ready = 1'b1;
    bus1.in_valid  = 1'b1;
    for (int i = 0; i < 11; i++) begin
      bus1.instr = {4'(i), 4'(i), 4'h5, 4'hC};
      step();
      e = {1'b1, exp_sel[i], exp_imm[i], 4'(i), 4'h5, 4'hC, 1'b1, 1'b0};
      n_checks++;
      if (obs1() !== e) begin
        n_fail++; $display("FAIL b2b_op%0d: got %h expected %h", i, obs1(), e);
      end
    end
    bus1.in_valid = 1'b0;
    step();
    n_checks++;
    if (bus1.out_valid !== 1'b0) begin
      n_fail++; $display("FAIL b2b_drain: out_valid got %b expected 0", bus1.out_valid);
    end
  endtask

  task automatic test_reset_two();
    logic [19:0] exp_rst;
    exp_rst = {1'b0, 4'hF, 1'b0, 4'h0, 4'h0, 4'h0, 1'b0, 1'b0};
    bus1.out_ready = 1'b0;
    bus1.in_valid  = 1'b1;
    bus1.instr     = 16'h4444;
    step();
    bus1.instr = 16'h5555;
    step();
    bus1.in_valid = 1'b0;
    n_checks++;
    if (bus1.in_ready !== 1'b0 || bus1.out_valid !== 1'b1) begin
      n_fail++; $display("FAIL rst2_full: in_ready %b out_valid %b expected 0 and 1",
                         bus1.in_ready, bus1.out_valid);
    end
    #2 reset = 1'b1;
    #1;
    n_checks++;
    if (obs1() !== exp_rst || bus1.in_ready !== 1'b0) begin
      n_fail++; $display("FAIL rst2_immediate: bundle %h in_ready %b expected %h and 0",
                         obs1(), bus1.in_ready, exp_rst);
    end
    n_checks++;
    if (bus1.err_count !== 16'd0 || bus2.err_count !== 2'd0) begin
      n_fail++; $display("FAIL rst2_err_count: got %0d and %0d expected 0 and 0",
                         bus1.err_count, bus2.err_count);
    end
    @(negedge clk);
    reset = 1'b0;
    bus1.out_ready = 1'b1;
    step();
    n_checks++;
    if (bus1.in_ready !== 1'b1) begin
      n_fail++; $display("FAIL rst2_ready: got %b expected 1", bus1.in_ready);
    end
    for (int i = 0; i < 3; i++) begin
      n_checks++;
      if (bus1.out_valid !== 1'b0) begin
        n_fail++; $display("FAIL rst2_stale_%0d: out_valid got %b expected 0", i, bus1.out_valid);
      end
      step();
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_decode();
    test_illegal();
    test_saturate();
    test_backpressure();
    test_back_to_back();
    test_reset_two();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/alu_op_decoder.md
ALU_OP_DECODER -- requirements
Module: alu_op_decoder

Interface
REQ-001 The block SHALL have parameter CNT_W, default 16, width of the illegal-opcode counter.
REQ-002 The block SHALL have port clk  input  1  single clock, all state updates on rising edge.
REQ-003 The block SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-004 The block SHALL have port in_valid  input  1  instruction word on instr is valid.
REQ-005 The block SHALL have port instr  input  16  instruction: [15:12] opcode, [11:8] rd, [7:4] rs, [3:0] rt/imm4.
REQ-006 The block SHALL have port in_ready  output  1  block can accept an instruction this cycle.
REQ-007 The block SHALL have port out_valid  output  1  decoded bundle valid.
REQ-008 The block SHALL have port out_ready  input  1  consumer accepts bundle this cycle.
REQ-009 The block SHALL have port alu_sel  output  4  ALU result-mux selector.
REQ-010 The block SHALL have port use_imm  output  1  operand B is zero-extended imm4, not register rt.
REQ-011 The block SHALL have ports rd, rs, rt  output  4 each  register fields passed through; rt also carries imm4/shift amount.
REQ-012 The block SHALL have port reg_we  output  1  result is written to rd.
REQ-013 The block SHALL have port illegal  output  1  bundle came from an undefined opcode.
REQ-014 The block SHALL have port err_count  output  CNT_W  saturating count of accepted illegal opcodes.

Function
REQ-015 Transfers SHALL occur on input only when in_valid and in_ready are both 1, on output only when out_valid and out_ready are both 1.
REQ-016 Opcode decode SHALL be: 0 ADD sel 0; 1 SUB sel 1; 2 AND sel 2; 3 OR sel 3; 4 NOR sel 4; 5 XOR sel 5; 6 SLL sel 6; 7 SRL sel 7; 8 SRA sel 8; 9 ADDI sel 0 use_imm 1; A SUBI sel 1 use_imm 1.
REQ-017 For opcodes 0-A, reg_we SHALL be 1 and illegal 0; use_imm SHALL be 0 except opcodes 9 and A.
REQ-018 Opcodes B-F SHALL decode to alu_sel 4'hF, use_imm 0, reg_we 0, illegal 1, fields still passed through.
REQ-019 Decode SHALL be registered: a bundle accepted at edge k SHALL be presented with out_valid 1 from edge k onward (visible in cycle k+1), latency exactly one cycle when the output is empty.
REQ-020 Storage SHALL be a 2-entry skid buffer with states EMPTY, ONE, TWO; in_ready SHALL be 1 in EMPTY and ONE, 0 in TWO, driven from registered state only.
REQ-021 Transitions: EMPTY->ONE on input transfer; ONE->TWO on input without output transfer; ONE->EMPTY on output without input; ONE stays ONE on simultaneous input and output; TWO->ONE on output transfer.
REQ-022 Bundles SHALL leave in acceptance order; no bundle SHALL be dropped or duplicated.
REQ-023 While out_valid is 1 and out_ready is 0, all output fields SHALL remain stable.
REQ-024 Sustained in_valid=1, out_ready=1 SHALL yield one bundle per cycle after the first.
REQ-025 err_count SHALL increment by 1 on each input transfer with opcode B-F and SHALL saturate at 2^CNT_W-1.
REQ-026 instr SHALL be ignored when no input transfer occurs.

Reset
REQ-027 reset asserted SHALL immediately force state EMPTY, out_valid 0, in_ready 0, err_count 0, alu_sel 4'hF, use_imm 0, reg_we 0, illegal 0, rd/rs/rt 0.
REQ-028 in_ready SHALL become 1 on the first rising clk after reset deasserts; reset mid-transfer SHALL discard all buffered bundles.

Structure
REQ-029 A shared package SHALL hold the opcode enum, the alu_sel encoding constants (0-8, 4'hF invalid), the decoded-bundle struct and the skid-state enum; the ALU result mux SHALL use the same selector constants.
REQ-030 The pure combinational opcode-to-bundle table SHALL be one sub-module, alu_op_table; storage and handshake live in alu_op_decoder.

Verification
REQ-031 Reset, then instr 16'h0123 in_valid 1 out_ready 1 -> next cycle out_valid 1, alu_sel 0, rd 1, rs 2, rt 3, reg_we 1, use_imm 0.
REQ-032 instr 16'h9A57 (ADDI) -> alu_sel 0, use_imm 1, rt 7; instr 16'h8334 (SRA) -> alu_sel 8, rt 4.
REQ-033 instr 16'hF000 -> alu_sel 4'hF, illegal 1, reg_we 0, err_count 1; with CNT_W=2, four illegal opcodes -> err_count holds 3.
REQ-034 out_ready 0, push 16'h1111, 16'h2222 -> in_ready 0 after second; third word held off; release out_ready -> bundles rd 1 then rd 2, then third accepted.
REQ-035 Stream opcodes 0..A back-to-back with out_ready 1 -> 11 bundles on 11 consecutive cycles, correct alu_sel each.
REQ-036 Assert reset with state TWO -> out_valid 0 immediately, no stale bundle emitted after release.
